// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch stage: FSM state type and the
//   bit positions of the decoder fields inside the 32-bit instruction word.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 29;
  localparam int V_BIT      = 28;
  localparam int FUNCT_MSB  = 27;
  localparam int FUNCT_LSB  = 25;

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response bus between the fetch stage (master)
//   and the instruction memory (slave). One request at a time; the response
//   strobe arrives one or more cycles after the accepted request.
//   imem_req    master -> slave  request, accepted in the cycle it is high
//   imem_addr   master -> slave  request address
//   imem_valid  slave -> master  response strobe
//   imem_rdata  slave -> master  instruction word, valid with imem_valid
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_valid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
//   IF/ID pipeline register with flush, hold and load controls.
//   Priority: flush > hold > load. When none is active the register takes a
//   bubble, so the decoder never sees the same instruction twice.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     flush                   clear valid and instruction (pc fields kept)
//     hold                    keep all contents unchanged
//     load                    capture instr_in / pc_in / pc_plus_in
//     instr_in, pc_in,
//     pc_plus_in              data captured on load
//     instr_o, pc_o,
//     pc_plus_o, valid_o      registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_register #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  hold,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [ADDR_WIDTH-1:0] pc_plus_in,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus_q, pc_plus_d;
  logic                  valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pc_plus_d = pc_plus_q;
    valid_d   = valid_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = '0;
    end else if (!hold) begin
      if (load) begin
        valid_d   = 1'b1;
        instr_d   = instr_in;
        pc_d      = pc_in;
        pc_plus_d = pc_plus_in;
      end else begin
        // All-zero word decodes as a register-writing op; valid_o=0 gates it.
        valid_d = 1'b0;
        instr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      pc_q      <= '0;
      pc_plus_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pc_plus_q <= pc_plus_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pc_plus_o = pc_plus_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch plus IF/ID register, feeding the control-unit decoder.
//   Keeps one instruction-memory request outstanding at most, tolerates any
//   response latency >= 1 cycle, honours decode stall and branch redirect.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_FETCH | issue request for pc (suppressed while a redirect is present)
//   S_WAIT  | request outstanding, waiting for imem_valid
//   S_HOLD  | word returned during stall, parked in skid buffer
//   S_DROP  | redirected while outstanding; discard the next response
//
//   Ports:
//     clk, rst_n         clock, async active-low reset
//     stall_d            hold IF/ID contents and pc
//     branch_taken_e     redirect to branch_target_e, flushes IF/ID
//     branch_target_e    redirect address (used unaligned as given)
//     imem               instruction-memory bus (master side)
//     instr_d, pc_d,
//     pc_plus_d, valid_d IF/ID contents
//     opcode_d, v_d,
//     funct_d            decoder fields sliced from instr_d
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_d,
  input  logic                  branch_taken_e,
  input  logic [ADDR_WIDTH-1:0] branch_target_e,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic [ADDR_WIDTH-1:0] pc_plus_d,
  output logic                  valid_d,
  output logic [2:0]            opcode_d,
  output logic                  v_d,
  output logic [2:0]            funct_d
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  load_en;
  logic [DATA_WIDTH-1:0] load_word;

  // Wraps silently modulo 2^ADDR_WIDTH.
  assign pc_inc = fetch_pc_q + PC_STEP;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    skid_d     = skid_q;
    load_en    = 1'b0;
    load_word  = imem.imem_rdata;

    unique case (state_q)
      S_FETCH: begin
        if (branch_taken_e) begin
          fetch_pc_d = branch_target_e;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (branch_taken_e) begin
          fetch_pc_d = branch_target_e;
          // A response in the same cycle is simply ignored; otherwise it is
          // still in flight and must be swallowed before the next request.
          state_d    = imem.imem_valid ? S_FETCH : S_DROP;
        end else if (imem.imem_valid) begin
          if (!stall_d) begin
            load_en    = 1'b1;
            load_word  = imem.imem_rdata;
            fetch_pc_d = pc_inc;
            state_d    = S_FETCH;
          end else begin
            skid_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (branch_taken_e) begin
          fetch_pc_d = branch_target_e;
          state_d    = S_FETCH;
        end else if (!stall_d) begin
          load_en    = 1'b1;
          load_word  = skid_q;
          fetch_pc_d = pc_inc;
          state_d    = S_FETCH;
        end
      end

      S_DROP: begin
        if (branch_taken_e) begin
          fetch_pc_d = branch_target_e;
        end
        if (imem.imem_valid) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      skid_q     <= skid_d;
    end
  end

  // Gated by rst_n so no request escapes while reset is held, even though
  // the state register already reads S_FETCH.
  assign imem.imem_req  = rst_n && (state_q == S_FETCH) && !branch_taken_e;
  assign imem.imem_addr = fetch_pc_q;

  if_id_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (branch_taken_e),
    .hold       (stall_d),
    .load       (load_en),
    .instr_in   (load_word),
    .pc_in      (fetch_pc_q),
    .pc_plus_in (pc_inc),
    .instr_o    (instr_d),
    .pc_o       (pc_d),
    .pc_plus_o  (pc_plus_d),
    .valid_o    (valid_d)
  );

  assign opcode_d = instr_d[OPCODE_MSB:OPCODE_LSB];
  assign v_d      = instr_d[V_BIT];
  assign funct_d  = instr_d[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed scenarios plus a randomized run. A transaction-level model tracks
//   the outstanding request, whether its response is still wanted, a parked
//   word during stall, and the expected IF/ID contents after every edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus_d;
  logic        valid_d;
  logic [2:0]  opcode_d;
  logic        v_d;
  logic [2:0]  funct_d;

  fetch_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem_bus ();

  fetch_stage #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0),
    .PC_STEP    (32'd4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_d         (stall_d),
    .branch_taken_e  (branch_taken_e),
    .branch_target_e (branch_target_e),
    .imem            (imem_bus),
    .instr_d         (instr_d),
    .pc_d            (pc_d),
    .pc_plus_d       (pc_plus_d),
    .valid_d         (valid_d),
    .opcode_d        (opcode_d),
    .v_d             (v_d),
    .funct_d         (funct_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory contents
  logic [31:0] seed;
  logic [31:0] mem_ovr [bit [31:0]];

  // model state
  int          cyc = 0;
  int          lat = 1;
  logic        pend_valid;
  logic        pend_live;
  logic [31:0] pend_addr;
  logic [31:0] pend_data;
  int          pend_due;
  logic        buffered;
  logic [31:0] buf_word;
  logic [31:0] buf_pc;
  logic [31:0] model_pc;
  logic        exp_valid;
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  logic [31:0] exp_pcp;

  // observation logs for directed scenarios
  logic [31:0] req_log [$];
  logic [31:0] del_pc  [$];
  logic [31:0] del_ins [$];
  logic [2:0]  del_op  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    del_pc.delete();
    del_ins.delete();
    del_op.delete();
  endtask

  task automatic deliver(input logic [31:0] w, input logic [31:0] a);
    exp_valid = 1'b1;
    exp_instr = w;
    exp_pc    = a;
    exp_pcp   = a + 32'd4;
    model_pc  = a + 32'd4;
  endtask

  // Called at a falling edge; asserts reset mid-cycle and checks async clear.
  task automatic do_reset();
    stall_d         = 1'b0;
    branch_taken_e  = 1'b0;
    branch_target_e = 32'h0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_d",   32'(valid_d), 32'h0);
    chk("rst_instr_d",   instr_d,      32'h0);
    chk("rst_pc_d",      pc_d,         32'h0);
    chk("rst_pc_plus_d", pc_plus_d,    32'h0);
    chk("rst_imem_req",  32'(imem_bus.imem_req), 32'h0);
    chk("rst_imem_addr", imem_bus.imem_addr, 32'h0);
    pend_valid = 1'b0;
    pend_live  = 1'b0;
    buffered   = 1'b0;
    model_pc   = 32'h0;
    exp_valid  = 1'b0;
    exp_instr  = 32'h0;
    exp_pc     = 32'h0;
    exp_pcp    = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check the request,
  // advance the model across the rising edge, then check IF/ID.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    logic        resp_now;
    logic        exp_req;
    logic [31:0] req_addr;
    stall_d         = st;
    branch_taken_e  = br;
    branch_target_e = tgt;
    resp_now = pend_valid && (pend_due == cyc);
    imem_bus.imem_valid = resp_now;
    imem_bus.imem_rdata = resp_now ? pend_data : $urandom();
    #1;
    exp_req  = !pend_valid && !buffered && !br;
    req_addr = model_pc;
    chk("imem_req", 32'(imem_bus.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_bus.imem_addr, req_addr);
    if (imem_bus.imem_req === 1'b1) req_log.push_back(imem_bus.imem_addr);

    if (br) begin
      exp_valid = 1'b0;
      exp_instr = 32'h0;
      buffered  = 1'b0;
      if (pend_valid && !resp_now) pend_live = 1'b0;
      model_pc  = tgt;
    end else if (st) begin
      if (resp_now && pend_live) begin
        buffered = 1'b1;
        buf_word = pend_data;
        buf_pc   = pend_addr;
      end
    end else if (buffered) begin
      deliver(buf_word, buf_pc);
      buffered = 1'b0;
    end else if (resp_now && pend_live) begin
      deliver(pend_data, pend_addr);
    end else begin
      exp_valid = 1'b0;
      exp_instr = 32'h0;
    end
    if (resp_now) pend_valid = 1'b0;
    if (exp_req) begin
      pend_valid = 1'b1;
      pend_live  = 1'b1;
      pend_addr  = req_addr;
      pend_data  = mem_word(req_addr);
      pend_due   = cyc + lat;
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("valid_d",   32'(valid_d),  32'(exp_valid));
    chk("instr_d",   instr_d,       exp_instr);
    chk("pc_d",      pc_d,          exp_pc);
    chk("pc_plus_d", pc_plus_d,     exp_pcp);
    chk("opcode_d",  32'(opcode_d), 32'(exp_instr[31:29]));
    chk("v_d",       32'(v_d),      32'(exp_instr[28]));
    chk("funct_d",   32'(funct_d),  32'(exp_instr[27:25]));
    if (valid_d === 1'b1) begin
      del_pc.push_back(pc_d);
      del_ins.push_back(instr_d);
      del_op.push_back(opcode_d);
    end
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n           = 1'b1;
    stall_d         = 1'b0;
    branch_taken_e  = 1'b0;
    branch_target_e = 32'h0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    seed = $urandom() | 32'h0200_0000;
    @(negedge clk);

    // 1: back-to-back with 1-cycle latency, fixed words 0 / 0x8000_0000
    do_reset();
    clear_logs();
    mem_ovr[32'h0] = 32'h0000_0000;
    mem_ovr[32'h4] = 32'h8000_0000;
    lat = 1;
    repeat (6) step(1'b0, 1'b0, 32'h0);
    chk("t1_req_count", 32'(req_log.size()), 32'd3);
    if (req_log.size() >= 3) begin
      chk("t1_addr0", req_log[0], 32'h0);
      chk("t1_addr1", req_log[1], 32'h4);
      chk("t1_addr2", req_log[2], 32'h8);
    end
    chk("t1_del_count", 32'(del_op.size()), 32'd3);
    if (del_op.size() >= 2) begin
      chk("t1_opcode0", 32'(del_op[0]), 32'h0);
      chk("t1_opcode1", 32'(del_op[1]), 32'h4);
    end
    mem_ovr.delete();

    // 2: 3-cycle latency
    do_reset();
    clear_logs();
    lat = 3;
    repeat (10) step(1'b0, 1'b0, 32'h0);
    chk("t2_req_count", 32'(req_log.size()), 32'd3);
    chk("t2_del_count", 32'(del_pc.size()), 32'd2);
    if (del_pc.size() >= 2) begin
      chk("t2_pc0", del_pc[0], 32'h0);
      chk("t2_pc1", del_pc[1], 32'h4);
    end

    // 3: 4-cycle stall while the response returns
    do_reset();
    clear_logs();
    lat = 2;
    step(1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b0, 32'h0);
    chk("t3_del_count", 32'(del_pc.size()), 32'd2);
    if (del_pc.size() >= 2) begin
      chk("t3_pc0",    del_pc[0],  32'h0);
      chk("t3_instr0", del_ins[0], mem_word(32'h0));
      chk("t3_pc1",    del_pc[1],  32'h4);
    end

    // 4: redirect to 0x40 while waiting; late word discarded
    do_reset();
    clear_logs();
    lat = 4;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h40);
    repeat (9) step(1'b0, 1'b0, 32'h0);
    chk("t4_req_count", 32'(req_log.size()), 32'd3);
    if (req_log.size() >= 2) chk("t4_redirect_addr", req_log[1], 32'h40);
    chk("t4_del_count", 32'(del_pc.size()), 32'd1);
    if (del_pc.size() >= 1) chk("t4_first_pc", del_pc[0], 32'h40);

    // 5: branch and stall together, flush wins
    do_reset();
    clear_logs();
    lat = 1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t5_valid_before", 32'(valid_d), 32'h1);
    step(1'b1, 1'b1, 32'h80);
    chk("t5_valid_after", 32'(valid_d), 32'h0);
    chk("t5_instr_after", instr_d, 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // 6: reset while waiting, then pc wrap at the top of the address space
    do_reset();
    lat = 4;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    do_reset();
    clear_logs();
    lat = 1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    chk("t6_req_count", 32'(req_log.size()), 32'd3);
    if (req_log.size() >= 3) begin
      chk("t6_first_addr", req_log[0], 32'h0);
      chk("t6_top_addr",   req_log[1], 32'hFFFF_FFFC);
      chk("t6_wrap_addr",  req_log[2], 32'h0);
    end
    if (del_pc.size() >= 2) chk("t6_wrap_pc_plus", del_pc[1] + 32'd4, 32'h0);

    // randomized run with random latency, stalls, redirects and one reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      lat = $urandom_range(1, 4);
      tgt = $urandom();
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
